id_hazard_scoreboard: RTL and testbench

Parametrised hazard scoreboard for the ID stage. It tracks every in-flight register write from EX through WB and returns a per-source forwarding select for each ID operand. It raises `stallreq` when an operand's producer has not yet made its result available. It replaces fixed EX/MEM/WB bus compares and the single-purpose load-use bubble with a result-latency model per instruction, so loads, multi-cycle ops and deeper pipelines share one mechanism.

---
 rtl/id_hazard_scoreboard.sv | 115 +++++++++++
 tb/tb_id_hazard_scoreboard.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_hazard_scoreboard.sv
// id_hazard_scoreboard
// ID-stage hazard scoreboard. Keeps a shift table of in-flight writers from
// EX (slot 0) to WB (slot PIPE_DEPTH-1), each carrying the first slot index at
// which its result can be forwarded. Per ID source operand it returns a
// forwarding select (0 = regfile, k = slot k-1) or requests a stall when the
// youngest matching producer is not yet ready.
// Optional build macro: SCOREBOARD_STATS_EN adds saturating stall/forward
// event counters and their output ports.
module id_hazard_scoreboard #(
   parameter int NUM_SRC    = 2,
   parameter int PIPE_DEPTH = 3,
   parameter int REG_AW     = 5,
   parameter int LAT_W      = 2,
   parameter int SEL_W      = $clog2(PIPE_DEPTH + 1)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        pipe_hold,
   input  logic                        issue_valid,
   input  logic                        issue_we,
   input  logic [REG_AW-1:0]           issue_waddr,
   input  logic [LAT_W-1:0]            issue_lat,
   input  logic [NUM_SRC-1:0]          src_valid,
   input  logic [NUM_SRC*REG_AW-1:0]   src_addr,
   output logic [NUM_SRC*SEL_W-1:0]    fwd_sel,
   output logic                        stallreq
`ifdef SCOREBOARD_STATS_EN
   ,
   output logic [31:0]                 stat_stall_cnt,
   output logic [31:0]                 stat_fwd_cnt
`endif
);

   logic              slot_valid [PIPE_DEPTH];
   logic              slot_we    [PIPE_DEPTH];
   logic [REG_AW-1:0] slot_waddr [PIPE_DEPTH];
   logic [LAT_W-1:0]  slot_lat   [PIPE_DEPTH];

   logic [SEL_W-1:0]  sel        [NUM_SRC];
   logic [NUM_SRC-1:0] hazard;
   logic              accept;

   assign stallreq = issue_valid & (|hazard);
   assign accept   = issue_valid & ~stallreq & ~pipe_hold;

   // Advance the in-flight table one stage per unfrozen edge; a stalled or
   // empty ID slot enters EX as a bubble. Writes to $0 are recorded as non-writers.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < PIPE_DEPTH; k++) begin
            slot_valid[k] <= 1'b0;
            slot_we[k]    <= 1'b0;
            slot_waddr[k] <= '0;
            slot_lat[k]   <= '0;
         end
      end else if (!pipe_hold) begin
         for (int k = PIPE_DEPTH - 1; k > 0; k--) begin
            slot_valid[k] <= slot_valid[k-1];
            slot_we[k]    <= slot_we[k-1];
            slot_waddr[k] <= slot_waddr[k-1];
            slot_lat[k]   <= slot_lat[k-1];
         end
         slot_valid[0] <= accept;
         slot_we[0]    <= accept & issue_we & (issue_waddr != '0);
         slot_waddr[0] <= issue_waddr;
         slot_lat[0]   <= issue_lat;
      end
   end

   // Per-source lookup: scan oldest to youngest so the youngest match wins.
   always_comb begin
      hazard = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         sel[i] = '0;
         if (src_valid[i] && (src_addr[i*REG_AW +: REG_AW] != '0)) begin
            for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
               if (slot_valid[k] && slot_we[k] &&
                   (slot_waddr[k] == src_addr[i*REG_AW +: REG_AW])) begin
                  if (k >= int'(slot_lat[k])) begin
                     sel[i]    = SEL_W'(k + 1);
                     hazard[i] = 1'b0;
                  end else begin
                     sel[i]    = '0;
                     hazard[i] = 1'b1;
                  end
               end
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_pack
      assign fwd_sel[g*SEL_W +: SEL_W] = sel[g];
   end

`ifdef SCOREBOARD_STATS_EN
   logic fwd_any;
   assign fwd_any = |fwd_sel;

   // Saturating event counters: real stall cycles, and accepted
   // instructions that used at least one forwarding path.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_stall_cnt <= '0;
         stat_fwd_cnt   <= '0;
      end else begin
         if (stallreq && !pipe_hold && (stat_stall_cnt != 32'hFFFF_FFFF))
            stat_stall_cnt <= stat_stall_cnt + 32'd1;
         if (accept && fwd_any && (stat_fwd_cnt != 32'hFFFF_FFFF))
            stat_fwd_cnt <= stat_fwd_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Testbench for id_hazard_scoreboard (default parameters: 2 sources,
// 3 tracked stages, 5-bit register addresses, 2-bit latency, 2-bit select).
module tb_id_hazard_scoreboard;

   logic        clk = 1'b0;
   logic        rst;
   logic        pipe_hold;
   logic        issue_valid;
   logic        issue_we;
   logic [4:0]  issue_waddr;
   logic [1:0]  issue_lat;
   logic [1:0]  src_valid;
   logic [9:0]  src_addr;
   logic [3:0]  fwd_sel;
   logic        stallreq;
`ifdef SCOREBOARD_STATS_EN
   logic [31:0] stat_stall_cnt;
   logic [31:0] stat_fwd_cnt;
`endif

   int vectors = 0;
   int miscompares = 0;

   id_hazard_scoreboard dut (
      .clk(clk),
      .rst(rst),
      .pipe_hold(pipe_hold),
      .issue_valid(issue_valid),
      .issue_we(issue_we),
      .issue_waddr(issue_waddr),
      .issue_lat(issue_lat),
      .src_valid(src_valid),
      .src_addr(src_addr),
      .fwd_sel(fwd_sel),
      .stallreq(stallreq)
`ifdef SCOREBOARD_STATS_EN
      ,
      .stat_stall_cnt(stat_stall_cnt),
      .stat_fwd_cnt(stat_fwd_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: list of accepted instructions with their age in
   // unfrozen cycles since acceptance; youngest at the front.
   typedef struct {
      logic [4:0] wa;
      logic       we;
      int         lat;
      int         age;
   } rec_t;
   rec_t q[$];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_issue(input logic v, input logic we, input logic [4:0] wa,
                              input logic [1:0] lat);
      issue_valid = v;
      issue_we    = we;
      issue_waddr = wa;
      issue_lat   = lat;
   endtask

   task automatic drive_src(input logic v0, input logic [4:0] a0,
                            input logic v1, input logic [4:0] a1);
      src_valid = {v1, v0};
      src_addr  = {a1, a0};
   endtask

   task automatic flush();
      drive_issue(1'b0, 1'b0, 5'd0, 2'd0);
      drive_src(1'b0, 5'd0, 1'b0, 5'd0);
      pipe_hold = 1'b0;
      repeat (4) step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      pipe_hold = 1'b0;
      drive_issue(1'b0, 1'b0, 5'd0, 2'd0);
      drive_src(1'b0, 5'd0, 1'b0, 5'd0);
      repeat (2) step();
      rst = 1'b0;
      drive_src(1'b1, 5'd3, 1'b1, 5'd9);
      @(negedge clk);
      vectors++;
      if (stallreq !== 1'b0 || fwd_sel !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_idle: stallreq=%b fwd_sel=%b, required 0/0000", stallreq, fwd_sel);
      end
      drive_issue(1'b1, 1'b0, 5'd0, 2'd0);
      @(negedge clk);
      vectors++;
      if (stallreq !== 1'b0 || fwd_sel !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_issue: stallreq=%b fwd_sel=%b, required 0/0000", stallreq, fwd_sel);
      end
`ifdef SCOREBOARD_STATS_EN
      vectors++;
      if (stat_stall_cnt !== 32'd0 || stat_fwd_cnt !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_stats: stall=%0d fwd=%0d, required 0/0", stat_stall_cnt, stat_fwd_cnt);
      end
`endif
      flush();
   endtask

   task automatic test_alu_fwd();
      drive_issue(1'b1, 1'b1, 5'd3, 2'd0);
      step();
      drive_issue(1'b1, 1'b0, 5'd0, 2'd0);
      drive_src(1'b1, 5'd3, 1'b0, 5'd0);
      @(negedge clk);
      vectors++;
      if (stallreq !== 1'b0 || fwd_sel !== 4'b0001) begin
         miscompares++;
         $display("FAIL alu_fwd_ex: stallreq=%b fwd_sel=%b, required 0/0001", stallreq, fwd_sel);
      end
      step();
      @(negedge clk);
      vectors++;
      if (stallreq !== 1'b0 || fwd_sel !== 4'b0010) begin
         miscompares++;
         $display("FAIL alu_fwd_mem: stallreq=%b fwd_sel=%b, required 0/0010", stallreq, fwd_sel);
      end
      flush();
   endtask

   task automatic test_load_use();
      drive_issue(1'b1, 1'b1, 5'd4, 2'd1);
      step();
      drive_issue(1'b1, 1'b0, 5'd0, 2'd0);
      drive_src(1'b1, 5'd4, 1'b1, 5'd4);
      @(negedge clk);
      vectors++;
      if (stallreq !== 1'b1) begin
         miscompares++;
         $display("FAIL load_use_stall: stallreq=%b, required 1", stallreq);
      end
      step();
      @(negedge clk);
      vectors++;
      if (stallreq !== 1'b0 || fwd_sel !== 4'b1010) begin
         miscompares++;
         $display("FAIL load_use_fwd: stallreq=%b fwd_sel=%b, required 0/1010", stallreq, fwd_sel);
      end
      step();
      @(negedge clk);
      vectors++;
      if (stallreq !== 1'b0 || fwd_sel !== 4'b1111) begin
         miscompares++;
         $display("FAIL load_use_bubble: stallreq=%b fwd_sel=%b, required 0/1111", stallreq, fwd_sel);
      end
      flush();
   endtask

   task automatic test_youngest();
      drive_issue(1'b1, 1'b1, 5'd5, 2'd0);
      step();
      step();
      drive_issue(1'b1, 1'b0, 5'd0, 2'd0);
      drive_src(1'b1, 5'd5, 1'b1, 5'd5);
      @(negedge clk);
      vectors++;
      if (stallreq !== 1'b0 || fwd_sel !== 4'b0101) begin
         miscompares++;
         $display("FAIL youngest_wins: stallreq=%b fwd_sel=%b, required 0/0101", stallreq, fwd_sel);
      end
      flush();
   endtask

   task automatic test_zero_reg();
      drive_issue(1'b1, 1'b1, 5'd0, 2'd1);
      step();
      drive_issue(1'b1, 1'b0, 5'd0, 2'd0);
      drive_src(1'b1, 5'd0, 1'b1, 5'd0);
      @(negedge clk);
      vectors++;
      if (stallreq !== 1'b0 || fwd_sel !== 4'b0000) begin
         miscompares++;
         $display("FAIL zero_reg: stallreq=%b fwd_sel=%b, required 0/0000", stallreq, fwd_sel);
      end
      flush();
   endtask

   task automatic test_long_lat_hold();
      int n;
      int hold_cycles;
`ifdef SCOREBOARD_STATS_EN
      logic [31:0] cnt0;
`endif
      for (int pass = 0; pass < 2; pass++) begin
         hold_cycles = (pass == 0) ? 0 : 2;
         drive_issue(1'b1, 1'b1, 5'd6, 2'd3);
         step();
         drive_issue(1'b1, 1'b0, 5'd0, 2'd0);
         drive_src(1'b1, 5'd6, 1'b0, 5'd0);
         n = 0;
`ifdef SCOREBOARD_STATS_EN
         @(negedge clk);
         cnt0 = stat_stall_cnt;
`endif
         for (int cyc = 0; cyc < 20; cyc++) begin
            pipe_hold = (cyc < hold_cycles);
            @(negedge clk);
            if (stallreq !== 1'b1) break;
            n++;
            step();
         end
         pipe_hold = 1'b0;
         vectors++;
         if (n != 3 + hold_cycles) begin
            miscompares++;
            $display("FAIL long_lat_stall_len(hold=%0d): cycles=%0d, required %0d",
                     hold_cycles, n, 3 + hold_cycles);
         end
         vectors++;
         if (fwd_sel !== 4'b0000) begin
            miscompares++;
            $display("FAIL long_lat_fwd: fwd_sel=%b, required 0000", fwd_sel);
         end
`ifdef SCOREBOARD_STATS_EN
         vectors++;
         if (stat_stall_cnt - cnt0 !== 32'd3) begin
            miscompares++;
            $display("FAIL long_lat_stat: delta=%0d, required 3", stat_stall_cnt - cnt0);
         end
`endif
         flush();
      end
   endtask

   task automatic test_reset_midflight();
      drive_issue(1'b1, 1'b1, 5'd7, 2'd1);
      step();
      drive_issue(1'b0, 1'b0, 5'd0, 2'd0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      drive_issue(1'b1, 1'b0, 5'd0, 2'd0);
      drive_src(1'b1, 5'd7, 1'b1, 5'd7);
      @(negedge clk);
      vectors++;
      if (stallreq !== 1'b0 || fwd_sel !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_midflight: stallreq=%b fwd_sel=%b, required 0/0000", stallreq, fwd_sel);
      end
`ifdef SCOREBOARD_STATS_EN
      vectors++;
      if (stat_stall_cnt !== 32'd0 || stat_fwd_cnt !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_midflight_stats: stall=%0d fwd=%0d, required 0/0",
                  stat_stall_cnt, stat_fwd_cnt);
      end
`endif
      flush();
   endtask

   task automatic test_random();
      logic [3:0]  exp_sel;
      logic        exp_stall;
      logic        haz;
      logic        found;
      logic [4:0]  a;
      logic        accepted;
`ifdef SCOREBOARD_STATS_EN
      logic [31:0] m_stall;
      logic [31:0] m_fwd;
`endif
      rst = 1'b1;
      step();
      rst = 1'b0;
      q.delete();
`ifdef SCOREBOARD_STATS_EN
      m_stall = 0;
      m_fwd   = 0;
`endif
      for (int cyc = 0; cyc < 600; cyc++) begin
         rst         = ($urandom_range(0, 99) < 2);
         pipe_hold   = ($urandom_range(0, 99) < 12);
         issue_valid = ($urandom_range(0, 99) < 80);
         issue_we    = ($urandom_range(0, 99) < 75);
         issue_waddr = 5'($urandom_range(0, 7));
         issue_lat   = 2'($urandom_range(0, 3));
         src_valid   = 2'($urandom_range(0, 3));
         src_addr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};

         exp_sel = 4'b0000;
         haz     = 1'b0;
         for (int i = 0; i < 2; i++) begin
            a = (i == 0) ? src_addr[4:0] : src_addr[9:5];
            found = 1'b0;
            if (src_valid[i] && a != 5'd0) begin
               foreach (q[j]) begin
                  if (!found && q[j].we && q[j].wa == a && q[j].wa != 5'd0) begin
                     found = 1'b1;
                     if (q[j].age >= q[j].lat) begin
                        if (i == 0) exp_sel[1:0] = 2'(q[j].age + 1);
                        else        exp_sel[3:2] = 2'(q[j].age + 1);
                     end else begin
                        haz = 1'b1;
                     end
                  end
               end
            end
         end
         exp_stall = issue_valid & haz;

         @(negedge clk);
         vectors++;
         if (stallreq !== exp_stall) begin
            miscompares++;
            $display("FAIL rand_stall cyc %0d: stallreq=%b, required %b", cyc, stallreq, exp_stall);
         end
         if (!exp_stall) begin
            vectors++;
            if (fwd_sel !== exp_sel) begin
               miscompares++;
               $display("FAIL rand_fwd cyc %0d: fwd_sel=%b, required %b", cyc, fwd_sel, exp_sel);
            end
         end
`ifdef SCOREBOARD_STATS_EN
         vectors++;
         if (stat_stall_cnt !== m_stall || stat_fwd_cnt !== m_fwd) begin
            miscompares++;
            $display("FAIL rand_stats cyc %0d: stall=%0d fwd=%0d, required %0d/%0d",
                     cyc, stat_stall_cnt, stat_fwd_cnt, m_stall, m_fwd);
         end
`endif
         accepted = issue_valid & ~exp_stall & ~pipe_hold;
         if (rst) begin
            q.delete();
`ifdef SCOREBOARD_STATS_EN
            m_stall = 0;
            m_fwd   = 0;
`endif
         end else begin
`ifdef SCOREBOARD_STATS_EN
            if (exp_stall && !pipe_hold) m_stall++;
            if (accepted && exp_sel != 4'b0000) m_fwd++;
`endif
            if (!pipe_hold) begin
               foreach (q[j]) q[j].age++;
               while (q.size() > 0 && q[q.size()-1].age >= 3) void'(q.pop_back());
               if (accepted)
                  q.push_front('{wa: issue_waddr, we: issue_we, lat: int'(issue_lat), age: 0});
            end
         end
         step();
      end
      rst = 1'b0;
      flush();
   endtask

   initial begin
      rst = 1'b1;
      pipe_hold = 1'b0;
      drive_issue(1'b0, 1'b0, 5'd0, 2'd0);
      drive_src(1'b0, 5'd0, 1'b0, 5'd0);
      test_reset();
      test_alu_fwd();
      test_load_use();
      test_youngest();
      test_zero_reg();
      test_long_lat_hold();
      test_reset_midflight();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
